uart_baud_detect: RTL and testbench
===================================

# uart_baud_detect

Auto-baud detector for the UART receive path. Once armed, it watches the serial input for a 0x55 sync character and measures the low start bit and the high bit 0 in 50 MHz clock cycles. It classifies both widths against the six supported baud rates and publishes the result as a 17-bit baud code in the same encoding the baud-clock generator accepts on its baud input (4800…57600). Its output feeds that generator's baud select, closing the loop between the line and the baud clocks.

## Interface
- CLK_HZ, 50_000_000, system clock frequency; nominal bit periods are derived from it.
- CNT_W, 14, measurement counter width; counts saturate at 2^CNT_W-1 = 16383.
- clk  input  1  system clock, 50 MHz.
- rst_n  input  1  reset; one clock; reset is asynchronous and active-low.
- i_rx  input  1  raw serial line, asynchronous, idle high.
- i_start  input  1  arm request, single-cycle pulse; ignored while o_busy=1.
- o_baud  output  17  detected baud code (4800, 9600, 14400, 19200, 38400, 57600); reset value 9600.
- o_valid  output  1  one-cycle pulse; o_baud was updated this cycle; reset 0.
- o_err  output  1  one-cycle pulse; detection failed and o_baud is unchanged; reset 0.
- o_busy  output  1  high from arm until the o_valid/o_err cycle; reset 0.

## Operation
- i_rx passes through a 2-FF synchronizer to give rx_s. All decisions use rx_s.
- FSM states: IDLE, ARM, MEAS_LOW, MEAS_HIGH, CLASSIFY, REPORT.
- IDLE: o_busy=0. i_start=1 moves to ARM.
- ARM: waits for rx_s=1 for at least 1 cycle, then for the first rx_s=0. On that cycle it clears the counter to 1 and moves to MEAS_LOW. This gives protection against arming mid-low.
- MEAS_LOW: counter increments each cycle while rx_s=0. On rx_s=1 it latches L=counter, reloads the counter to 1, and moves to MEAS_HIGH.
- MEAS_HIGH: counter increments while rx_s=1. On rx_s=0 it latches H and moves to CLASSIFY.
- Timeout: if the counter reaches 16383 in either MEAS state, the FSM goes to REPORT with an error.
- Nominal periods N (cycles) = CLK_HZ/baud, truncated: 10416, 5208, 3472, 2604, 1302, 868.
- A width W matches baud b when |W − N_b| ≤ N_b>>3 (±12.5%). The resulting windows do not overlap:
  - 9114–11718
  - 4557–5859
  - 3038–3906
  - 2279–2929
  - 1140–1464
  - 760–976
- CLASSIFY (1 cycle): success only if L and H both match, and match the same baud.
- Arithmetic: unsigned compare, with CNT_W+1 bits for the difference.
- REPORT (1 cycle):
  - Success: o_baud ← code, o_valid=1.
  - Otherwise: o_err=1, o_baud held.
  - The FSM then returns to IDLE.
- o_valid and o_err are never asserted together. Both are registered outputs.

## Timing
- Synchronizer latency: 2 cycles from an i_rx edge to the rx_s edge.
- L equals the number of cycles rx_s is low. An ideal 19200 start bit of 2604 cycles gives L=2604; H is defined the same way for the high bit.
- The falling edge ending bit 0 (rx_s) is sampled in MEAS_HIGH. CLASSIFY follows in the next cycle, and o_valid/o_err plus the updated o_baud are visible the cycle after (REPORT).
- o_busy is 1 from the cycle after i_start through the REPORT cycle. It is 0 in the following cycle.
- i_start arriving in the REPORT cycle is ignored. A new arm requires i_start while in IDLE.
- Reset asserted in any state:
  - State returns to IDLE immediately (asynchronous).
  - Outputs take their reset values; o_baud returns to 9600.
  - The synchronizer flops reset to 1 (idle).
- Bits after bit 0 of the sync character are ignored.

## Structure
- Shared uart_pkg:
  - baud code constants.
  - nominal period constants as functions of CLK_HZ.
  - the state enum typedef.
  - the tolerance shift (3).
- One sub-module, uart_rx_sync: 2-FF synchronizer with reset value 1. It is reusable by the UART receiver.
- The classifier is a function in uart_pkg returning {match, code}, evaluated once each for L and H.

## Test plan
- Reset → o_baud=9600, o_valid=0, o_err=0, o_busy=0. No pulses while idle with i_rx toggling and no i_start.
- Arm, then drive 0x55 at 2604 cycles/bit → one o_valid pulse with o_baud=19200. Repeat for all six rates; 57600 uses 868 cycles/bit.
- Start bit 5208 low then bit 0 2604 high (mismatch) → o_err pulse; o_baud keeps its previous value; o_valid stays 0.
- Low 7000 cycles (outside all windows) → o_err; tolerance edges: low/high 760 → 57600 accepted, 759 → o_err.
- Arm with i_rx held low for 20000 cycles, then high then low:
  - No detection occurs while the line is stuck low.
  - After the line goes high, the next low run is measured. Holding it low ≥16383 cycles → o_err at timeout.
- rst_n pulsed low mid MEAS_LOW → immediate IDLE with reset outputs. i_start pulsed during MEAS_HIGH → ignored; exactly one result pulse.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, detector state encoding and the baud-width classifier.
package uart_pkg;

  localparam int unsigned DEF_CLK_HZ = 50_000_000;
  localparam int unsigned DEF_CNT_W  = 14;
  localparam int unsigned TOL_SHIFT  = 3;
  localparam int          NUM_BAUDS  = 6;

  localparam logic [16:0] BAUD_4800  = 17'd4800;
  localparam logic [16:0] BAUD_9600  = 17'd9600;
  localparam logic [16:0] BAUD_14400 = 17'd14400;
  localparam logic [16:0] BAUD_19200 = 17'd19200;
  localparam logic [16:0] BAUD_38400 = 17'd38400;
  localparam logic [16:0] BAUD_57600 = 17'd57600;

  localparam logic [16:0] BAUD_CODES [NUM_BAUDS] = '{
    BAUD_4800, BAUD_9600, BAUD_14400, BAUD_19200, BAUD_38400, BAUD_57600
  };

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_MEAS_LOW,
    ST_MEAS_HIGH,
    ST_CLASSIFY,
    ST_REPORT
  } bd_state_t;

  typedef struct packed {
    logic        match;
    logic [16:0] code;
  } baud_class_t;

  typedef logic [DEF_CNT_W:0] bd_diff_t;

  function automatic int unsigned nominal_period(input int unsigned clk_hz,
                                                 input logic [16:0] baud);
    return clk_hz / {15'd0, baud};
  endfunction

  // Windows are +/- N>>3 around each nominal period; they never overlap, so first hit wins.
  function automatic baud_class_t classify(input logic [DEF_CNT_W-1:0] w,
                                           input int unsigned clk_hz);
    baud_class_t r;
    bd_diff_t    n;
    bd_diff_t    tol;
    bd_diff_t    wx;
    bd_diff_t    diff;
    r.match = 1'b0;
    r.code  = BAUD_9600;
    wx      = bd_diff_t'(w);
    for (int i = 0; i < NUM_BAUDS; i++) begin
      n    = bd_diff_t'(nominal_period(clk_hz, BAUD_CODES[i]));
      tol  = n >> TOL_SHIFT;
      diff = (wx >= n) ? (wx - n) : (n - wx);
      if (!r.match && (diff <= tol)) begin
        r.match = 1'b1;
        r.code  = BAUD_CODES[i];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an idle-high serial line; both flops reset to idle.
module uart_rx_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic rx,
  output logic rx_s
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      meta <= rx;
      rx_s <= meta;
    end
  end

endmodule

// File: rtl/uart_baud_detect.sv
// Auto-baud detector: times the start bit and bit 0 of a 0x55 sync character
// and publishes the matching baud code for the baud-clock generator.
//
// state        | meaning
// IDLE         | not armed, waiting for i_start
// ARM          | waiting for line high, then the first falling edge
// MEAS_LOW     | counting the low start bit
// MEAS_HIGH    | counting the high bit 0
// CLASSIFY     | matching both widths against the baud windows
// REPORT       | result pulse cycle, then back to IDLE
module uart_baud_detect
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = DEF_CLK_HZ,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_rx,
  input  logic        i_start,
  output logic [16:0] o_baud,
  output logic        o_valid,
  output logic        o_err,
  output logic        o_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  bd_state_t        state;
  logic             rx_s;
  logic             seen_high;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] len_l;
  logic [CNT_W-1:0] len_h;
  baud_class_t      cls_l;
  baud_class_t      cls_h;
  logic             cls_ok;

  uart_rx_sync u_rx_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .rx   (i_rx),
    .rx_s (rx_s)
  );

  always_comb begin
    cls_l  = classify(DEF_CNT_W'(len_l), CLK_HZ);
    cls_h  = classify(DEF_CNT_W'(len_h), CLK_HZ);
    cls_ok = cls_l.match && cls_h.match && (cls_l.code == cls_h.code);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      seen_high <= 1'b0;
      cnt       <= '0;
      len_l     <= '0;
      len_h     <= '0;
      o_baud    <= BAUD_9600;
      o_valid   <= 1'b0;
      o_err     <= 1'b0;
      o_busy    <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_err   <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            seen_high <= 1'b0;
            o_busy    <= 1'b1;
            state     <= ST_ARM;
          end
        end
        // Requiring a high sample first keeps an arm during a low run from measuring it.
        ST_ARM: begin
          if (rx_s) begin
            seen_high <= 1'b1;
          end else if (seen_high) begin
            cnt   <= CNT_ONE;
            state <= ST_MEAS_LOW;
          end
        end
        ST_MEAS_LOW: begin
          if (rx_s) begin
            len_l <= cnt;
            cnt   <= CNT_ONE;
            state <= ST_MEAS_HIGH;
          end else if (cnt == CNT_MAX) begin
            o_err <= 1'b1;
            state <= ST_REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_MEAS_HIGH: begin
          if (!rx_s) begin
            len_h <= cnt;
            state <= ST_CLASSIFY;
          end else if (cnt == CNT_MAX) begin
            o_err <= 1'b1;
            state <= ST_REPORT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_CLASSIFY: begin
          if (cls_ok) begin
            o_baud  <= cls_l.code;
            o_valid <= 1'b1;
          end else begin
            o_err <= 1'b1;
          end
          state <= ST_REPORT;
        end
        ST_REPORT: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          o_busy <= 1'b0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_baud_detect.sv
// Bench for uart_baud_detect: table of measured widths plus corner-case sequences.
module tb_uart_baud_detect;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_rx = 1'b1;
  logic        i_start = 1'b0;
  logic [16:0] o_baud;
  logic        o_valid;
  logic        o_err;
  logic        o_busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit          ok;
    logic [16:0] baud;
  } exp_t;

  typedef struct {
    int          low;
    int          high;
    bit          ok;
    logic [16:0] code;
    bit          poke;
  } vec_t;

  exp_t        sb[$];
  vec_t        tbl[10];
  logic [16:0] model_baud = 17'd9600;

  always #10 clk = ~clk;

  uart_baud_detect dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_rx   (i_rx),
    .i_start(i_start),
    .o_baud (o_baud),
    .o_valid(o_valid),
    .o_err  (o_err),
    .o_busy (o_busy)
  );

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic expect_result(input bit ok, input logic [16:0] code);
    exp_t e;
    if (ok) model_baud = code;
    e.ok   = ok;
    e.baud = model_baud;
    sb.push_back(e);
  endtask

  // Result monitor: every valid/err pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (o_valid || o_err)) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_pulse: got valid=%0b err=%0b want none (t=%0t)",
                 o_valid, o_err, $time);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("result_kind", {30'd0, o_valid, o_err}, e.ok ? 32'd2 : 32'd1);
        check("result_baud", {15'd0, o_baud}, {15'd0, e.baud});
      end
    end
  end

  task automatic drive(input logic v, input int n);
    i_rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
  endtask

  task automatic wait_result(input int limit);
    int c;
    c = 0;
    while (sb.size() != 0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    check("result_arrived", sb.size(), 0);
    sb.delete();
  endtask

  task automatic run_meas(input vec_t v);
    expect_result(v.ok, v.code);
    pulse_start();
    check("busy_armed", {31'd0, o_busy}, 1);
    drive(1'b1, 4);
    drive(1'b0, v.low);
    if (v.poke) begin
      drive(1'b1, v.high / 2);
      i_start = 1'b1;
      drive(1'b1, 1);
      i_start = 1'b0;
      drive(1'b1, v.high - v.high / 2 - 1);
    end else begin
      drive(1'b1, v.high);
    end
    drive(1'b0, 20);
    drive(1'b1, 4);
    wait_result(100);
    drive(1'b1, 2);
    check("busy_done", {31'd0, o_busy}, 0);
  endtask

  initial begin
    int c;
    tbl[0] = '{low: 5208,  high: 5208,  ok: 1'b1, code: 17'd9600,  poke: 1'b0};
    tbl[1] = '{low: 10416, high: 10416, ok: 1'b1, code: 17'd4800,  poke: 1'b0};
    tbl[2] = '{low: 3472,  high: 3472,  ok: 1'b1, code: 17'd14400, poke: 1'b0};
    tbl[3] = '{low: 1302,  high: 1302,  ok: 1'b1, code: 17'd38400, poke: 1'b0};
    tbl[4] = '{low: 868,   high: 868,   ok: 1'b1, code: 17'd57600, poke: 1'b1};
    tbl[5] = '{low: 760,   high: 760,   ok: 1'b1, code: 17'd57600, poke: 1'b0};
    tbl[6] = '{low: 2604,  high: 2604,  ok: 1'b1, code: 17'd19200, poke: 1'b0};
    tbl[7] = '{low: 5208,  high: 2604,  ok: 1'b0, code: 17'd0,     poke: 1'b0};
    tbl[8] = '{low: 7000,  high: 10,    ok: 1'b0, code: 17'd0,     poke: 1'b0};
    tbl[9] = '{low: 759,   high: 760,   ok: 1'b0, code: 17'd0,     poke: 1'b0};

    repeat (3) @(negedge clk);
    check("rst_baud",  {15'd0, o_baud}, 9600);
    check("rst_valid", {31'd0, o_valid}, 0);
    check("rst_err",   {31'd0, o_err}, 0);
    check("rst_busy",  {31'd0, o_busy}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Line activity without an arm request must not produce anything.
    for (int i = 0; i < 8; i++) drive(i[0], 25);
    drive(1'b1, 10);
    check("idle_busy", {31'd0, o_busy}, 0);
    check("idle_baud", {15'd0, o_baud}, 9600);

    for (int i = 0; i < 10; i++) run_meas(tbl[i]);

    // Armed while the line is stuck low: nothing happens until it goes high.
    drive(1'b0, 3);
    pulse_start();
    drive(1'b0, 16400);
    check("stuck_busy", {31'd0, o_busy}, 1);
    check("stuck_baud", {15'd0, o_baud}, 19200);
    expect_result(1'b0, 17'd0);
    drive(1'b1, 5);
    i_rx = 1'b0;
    c = 0;
    while (!o_err && c < 17000) begin
      @(negedge clk);
      c++;
    end
    check("timeout_latency", c, 16386);
    wait_result(10);
    drive(1'b1, 5);
    check("timeout_busy", {31'd0, o_busy}, 0);

    // Asynchronous reset in the middle of the low measurement.
    pulse_start();
    drive(1'b1, 4);
    drive(1'b0, 300);
    rst_n = 1'b0;
    #1;
    check("midrst_busy",  {31'd0, o_busy}, 0);
    check("midrst_baud",  {15'd0, o_baud}, 9600);
    check("midrst_valid", {31'd0, o_valid}, 0);
    check("midrst_err",   {31'd0, o_err}, 0);
    model_baud = 17'd9600;
    @(negedge clk);
    i_rx  = 1'b1;
    rst_n = 1'b1;
    drive(1'b1, 10);
    check("post_rst_busy", {31'd0, o_busy}, 0);

    check("sb_drained", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

endmodule
